// File: rtl/fmap_readout.sv
// Feature-map readout: captures one frame of per-position filter pairs from the
// conv stage, then drains it byte-by-byte to the host over valid/ready.
module fmap_readout #(
    parameter int NUM_POS = 36,
    parameter int NUM_CH  = 2,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data_0,
    input  logic [DATA_W-1:0] in_data_1,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              frame_done,
    output logic              busy,
    output logic              overflow
);
    localparam int DEPTH = NUM_POS * NUM_CH;
    localparam int PW    = (NUM_POS > 1) ? $clog2(NUM_POS) : 1;
    localparam int RW    = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST_POS = PW'(NUM_POS - 1);
    localparam logic [RW-1:0] LAST_RD  = RW'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     wr_pos_q, wr_pos_d;
    logic [RW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              frame_done_q, frame_done_d;
    logic              overflow_q, overflow_d;
    logic              wr_en;
    logic [PW:0]       wr_addr0, wr_addr1;
    logic [RW-1:0]     rd_nxt;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Filter 0 lands at the even address, filter 1 at the odd one.
    assign wr_addr0 = {wr_pos_q, 1'b0};
    assign wr_addr1 = {wr_pos_q, 1'b1};
    assign rd_nxt   = rd_ptr_q + RW'(1);

    always_comb begin
        state_d      = state_q;
        wr_pos_d     = wr_pos_q;
        rd_ptr_d     = rd_ptr_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q;
        wr_en        = 1'b0;

        if (frame_start) begin
            // Restart wins over everything, including a pending handshake.
            state_d     = S_COLLECT;
            wr_pos_d    = '0;
            rd_ptr_d    = '0;
            overflow_d  = 1'b0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) overflow_d = 1'b1;
                end
                S_COLLECT: begin
                    if (in_valid) begin
                        wr_en = 1'b1;
                        if (wr_pos_q == LAST_POS) begin
                            wr_pos_d    = '0;
                            rd_ptr_d    = '0;
                            state_d     = S_DRAIN;
                            out_valid_d = 1'b1;
                            out_last_d  = 1'b0;
                            // Address 0 is only being written now in a one-position frame.
                            out_data_d  = (wr_pos_q == '0) ? in_data_0 : mem_q[0];
                        end else begin
                            wr_pos_d = wr_pos_q + PW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (in_valid) overflow_d = 1'b1;
                    if (out_valid_q && out_ready) begin
                        if (out_last_q) begin
                            out_valid_d  = 1'b0;
                            out_last_d   = 1'b0;
                            frame_done_d = 1'b1;
                            rd_ptr_d     = '0;
                            state_d      = S_IDLE;
                        end else begin
                            rd_ptr_d   = rd_nxt;
                            out_data_d = mem_q[rd_nxt];
                            out_last_d = (rd_nxt == LAST_RD);
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wr_pos_q     <= '0;
            rd_ptr_q     <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_pos_q     <= wr_pos_d;
            rd_ptr_q     <= rd_ptr_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr0] <= in_data_0;
            mem_q[wr_addr1] <= in_data_1;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
    assign busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_fmap_readout.sv
// Randomized scoreboard bench for fmap_readout: a queue model of the frame
// feeds expected bytes; a negedge monitor pops them on every handshake.
module tb_fmap_readout;
    localparam int NP = 36;
    localparam int NB = 72;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data_0 = '0;
    logic [7:0] in_data_1 = '0;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_valid, out_last, frame_done, busy, overflow;

    fmap_readout #(.NUM_POS(NP), .NUM_CH(2), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .in_valid(in_valid),
        .in_data_0(in_data_0), .in_data_1(in_data_1), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .frame_done(frame_done), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        bit         last;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] pos0[$];
    logic [7:0] pos1[$];
    bit         collecting = 1'b0;
    bit         ovf_m = 1'b0;
    int         compared = 0;
    int         mismatched = 0;
    int         rmode = 0;
    int         kstep = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endfunction

    // Monitor: scoreboard pops, hold stability under backpressure, frame_done timing.
    bit         done_exp = 1'b0;
    bit         have_hold = 1'b0;
    logic [7:0] hold_data = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            done_exp  = 1'b0;
            have_hold = 1'b0;
        end else begin
            if (frame_done || done_exp) check("frame_done", frame_done, done_exp);
            done_exp = 1'b0;
            if (have_hold && out_valid) check("hold_data", out_data, hold_data);
            have_hold = out_valid && !out_ready;
            hold_data = out_data;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL spurious_byte: got %0h required none", out_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_last", out_last, e.last);
                    done_exp = e.last;
                end
            end
        end
    end

    task automatic step(input bit fs, input bit iv, input logic [7:0] d0, input logic [7:0] d1);
        frame_start = fs;
        in_valid    = iv;
        in_data_0   = d0;
        in_data_1   = d1;
        case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = (kstep % 4 == 0) || (kstep % 4 == 3);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        kstep++;
        @(posedge clk);
        #1;
        if (fs) begin
            collecting = 1'b1;
            pos0.delete();
            pos1.delete();
            exp_q.delete();
            ovf_m = 1'b0;
        end else if (iv) begin
            if (collecting) begin
                pos0.push_back(d0);
                pos1.push_back(d1);
                if (pos0.size() == NP) begin
                    for (int p = 0; p < NP; p++) begin
                        exp_q.push_back('{pos0[p], 1'b0});
                        exp_q.push_back('{pos1[p], (p == NP - 1)});
                    end
                    collecting = 1'b0;
                    pos0.delete();
                    pos1.delete();
                end
            end else begin
                ovf_m = 1'b1;
            end
        end
        frame_start = 1'b0;
        in_valid    = 1'b0;
        check("busy", busy, collecting || (exp_q.size() != 0));
        check("overflow", overflow, ovf_m);
    endtask

    task automatic do_reset(input int n);
        rst_n       = 1'b0;
        frame_start = 1'b0;
        in_valid    = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
        collecting = 1'b0;
        pos0.delete();
        pos1.delete();
        exp_q.delete();
        ovf_m = 1'b0;
        check("rst_out_data", out_data, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        rst_n = 1'b1;
    endtask

    task automatic send_positions(input int n, input bit rnd, input bit gaps);
        for (int p = 0; p < n; p++) begin
            logic [7:0] a, b;
            if (gaps) begin
                int g = $urandom_range(0, 2);
                for (int i = 0; i < g; i++) step(1'b0, 1'b0, 8'h00, 8'h00);
            end
            a = rnd ? 8'($urandom) : 8'(p);
            b = rnd ? 8'($urandom) : 8'(8'h80 + p);
            step(1'b0, 1'b1, a, b);
        end
    endtask

    task automatic send_frame(input bit rnd, input bit gaps);
        send_positions(NP, rnd, gaps);
        check("drain_start_valid", out_valid, 1);
    endtask

    task automatic drain(input int ovf_at, input int abort_at, output int cycles);
        bit fired = 1'b0;
        cycles = 0;
        while (exp_q.size() != 0 && cycles < 1000) begin
            int rem = exp_q.size();
            cycles++;
            if (!fired && abort_at >= 0 && rem == NB - abort_at) begin
                fired = 1'b1;
                step(1'b1, 1'b0, 8'h00, 8'h00);
                check("abort_out_valid", out_valid, 0);
                return;
            end else if (!fired && ovf_at >= 0 && rem == NB - ovf_at) begin
                fired = 1'b1;
                step(1'b0, 1'b1, 8'h55, 8'h55);
            end else begin
                step(1'b0, 1'b0, 8'h00, 8'h00);
            end
        end
        if (exp_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain_timeout: got %0d bytes left required 0", exp_q.size());
        end
        step(1'b0, 1'b0, 8'h00, 8'h00);
        check("idle_after_drain", out_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        do_reset(2);

        step(1'b0, 1'b1, 8'hAA, 8'hAA);
        check("idle_in_valid_out_valid", out_valid, 0);
        step(1'b0, 1'b0, 8'h00, 8'h00);
        check("idle_out_valid", out_valid, 0);

        rmode = 0;
        step(1'b1, 1'b0, 8'h00, 8'h00);
        send_frame(1'b0, 1'b0);
        drain(-1, -1, cyc);
        check("throughput_cycles", cyc, NB);

        rmode = 1;
        step(1'b1, 1'b0, 8'h00, 8'h00);
        send_frame(1'b0, 1'b1);
        drain(-1, -1, cyc);

        rmode = 0;
        step(1'b1, 1'b0, 8'h00, 8'h00);
        send_frame(1'b1, 1'b1);
        drain(10, -1, cyc);
        check("ovf_drain_cycles", cyc, NB);
        step(1'b1, 1'b0, 8'h00, 8'h00);
        send_frame(1'b1, 1'b0);
        drain(-1, -1, cyc);

        step(1'b1, 1'b0, 8'h00, 8'h00);
        send_frame(1'b1, 1'b0);
        drain(-1, 20, cyc);
        rmode = 2;
        send_frame(1'b1, 1'b1);
        drain(-1, -1, cyc);

        rmode = 0;
        step(1'b1, 1'b1, 8'hEE, 8'hEE);
        send_frame(1'b1, 1'b0);
        drain(-1, -1, cyc);

        step(1'b1, 1'b0, 8'h00, 8'h00);
        send_positions(17, 1'b1, 1'b0);
        do_reset(1);
        check("midrst_busy", busy, 0);
        check("midrst_out_valid", out_valid, 0);

        rmode = 2;
        for (int f = 0; f < 2; f++) begin
            step(1'b1, 1'b0, 8'h00, 8'h00);
            send_frame(1'b1, 1'b1);
            drain(-1, -1, cyc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/fmap_readout.md
Name: fmap_readout

Overview:
- Reader/consumer for the conv feature-map stream. Captures each per-position result pair (filter 0, filter 1) from the conv stage into a frame buffer.
- Once a full frame is captured, drains it byte-by-byte to the host over a valid/ready handshake, intended for uo_out with ready/valid on uio.
- Sits between the conv/activation output and the top-level output registers. Makes all 36x2 results observable instead of only the last value.

Parameters:
- NUM_POS, 36, conv output positions per frame (6x6).
- NUM_CH, 2, filters per position.
- DATA_W, 8, bits per feature value.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- frame_start  input  1  one-cycle pulse; clears buffer pointers and flags, enters COLLECT.
- in_valid  input  1  one-cycle strobe; in_data_0/in_data_1 valid for the current position.
- in_data_0  input  DATA_W  filter-0 result.
- in_data_1  input  DATA_W  filter-1 result.
- out_data  output  DATA_W  byte being presented to host (registered).
- out_valid  output  1  out_data valid.
- out_ready  input  1  host accepts byte; synchronous to clk.
- out_last  output  1  high with final byte of frame (index NUM_POS*NUM_CH-1).
- frame_done  output  1  one-cycle pulse after final byte handshake.
- busy  output  1  high in COLLECT or DRAIN.
- overflow  output  1  sticky; in_valid arrived outside COLLECT.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE, wr_pos=0, rd_ptr=0.
  - out_data=0, out_valid=0, out_last=0, frame_done=0, busy=0, overflow=0.
  - Buffer contents are don't-care.
- Buffer:
  - NUM_POS*NUM_CH entries.
  - Position p stores filter 0 at address 2p and filter 1 at 2p+1.
  - Drain order is ascending address: p0f0, p0f1, p1f0, ...
- States IDLE, COLLECT, DRAIN:
  - IDLE: outputs idle. frame_start -> COLLECT.
  - COLLECT: on in_valid, write both bytes at wr_pos and increment wr_pos.
    - If the write is at wr_pos==NUM_POS-1: wr_pos<=0, rd_ptr<=0, go to DRAIN.
    - out_valid rises on the cycle after that final in_valid (1-cycle latency).
    - out_data=buf[0] at that point.
  - DRAIN: out_valid=1, out_data=buf[rd_ptr], out_last=(rd_ptr==NUM_POS*NUM_CH-1).
    - out_valid&&out_ready: rd_ptr++, and out_data updates the next cycle.
    - Without out_ready: out_data, out_valid and out_last are held stable.
    - Handshake on the last byte: out_valid<=0, frame_done pulses 1 cycle, state -> IDLE.
- busy=1 in COLLECT and DRAIN.
- Throughput: one byte per cycle with out_ready held high, giving 72 consecutive transfer cycles.
- overflow is set by in_valid in IDLE or DRAIN. The data is dropped and the buffer is untouched. overflow clears only on frame_start or reset.
- frame_start priority:
  - frame_start in any state takes priority. It sets wr_pos=0, rd_ptr=0, overflow=0, out_valid=0, state=COLLECT.
  - in_valid in the same cycle is ignored (not written, no overflow).
  - frame_start during DRAIN aborts the drain without a frame_done.
- Reset mid-operation: immediate return to reset state on the next posedge. No partial frame_done.
- Widths: wr_pos is ceil(log2(NUM_POS)) bits; rd_ptr is ceil(log2(NUM_POS*NUM_CH)) bits. Neither wraps silently; both are explicitly cleared at the end of the frame.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 1 -> all outputs 0 and busy=0. in_valid with 0xAA -> overflow=1, out_valid stays 0.
- Full frame, ready always high:
  - Stimulus: frame_start, then 36 in_valid with in_data_0=p and in_data_1=0x80+p.
  - Required: out_valid one cycle after the 36th strobe. Bytes 00,80,01,81,...,23,A3 on 72 consecutive cycles. out_last only on 0xA3. frame_done pulses the cycle after.
- Backpressure: the same frame with out_ready toggling 1,0,0,1 -> out_data stable while not ready, no byte lost or duplicated, 72 handshakes total.
- Overflow during drain: in_valid with 0x55 at rd_ptr=10 -> overflow=1, drained sequence unchanged. The next frame_start clears overflow.
- Abort: frame_start at rd_ptr=20 -> out_valid=0 next cycle, no frame_done, state COLLECT with wr_pos=0. A new 36-position frame then drains correctly from byte 0.
- Simultaneous events and reset mid-operation:
  - frame_start and in_valid in the same cycle -> that in_valid is not stored, and the first byte drained comes from the next in_valid.
  - rst_n=0 mid-COLLECT at wr_pos=17 -> busy=0 and out_valid=0 next cycle.
